// File: rtl/key_sequencer.sv
// key_sequencer: plays a stored digit code MSB-first as one-cycle b0/b1 presses toward the lock FSM.
// Define KEY_SEQUENCER_VERIFY_EN to add the unlock window after the last press and pass/fail reporting.
module key_sequencer #(
    parameter int MAX_LEN     = 8,
    parameter int GAP         = 2,
    parameter int UNLOCK_WAIT = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [MAX_LEN-1:0] code,
    input  logic [3:0]         len,
    input  logic               unlock,
    output logic               b0,
    output logic               b1,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic               fail,
    output logic [2:0]         state_o
);

`ifdef KEY_SEQUENCER_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP + 1) : 1;
    localparam int WIN_W = $clog2(UNLOCK_WAIT + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRESS = 3'd1,
        S_GAP   = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             state_q;
    logic [MAX_LEN-1:0] code_q;
    logic [IDX_W-1:0]   idx_q;
    logic [GAP_W-1:0]   gap_q;
    logic [WIN_W-1:0]   win_q;
    logic               b0_q, b1_q, busy_q, done_q, pass_q, fail_q;

    logic [IDX_W-1:0]   idx_first_d;
    logic [IDX_W-1:0]   idx_dec_d;
    logic               len_zero_d;
    logic               in_window_d;

    // start is a level request: it is acted on only on an edge where the FSM is
    // in IDLE; in every other state it is ignored, and no handshake back is given.
    always_comb begin
        idx_first_d = '0;
        if (int'(len) >= MAX_LEN)
            idx_first_d = IDX_W'(MAX_LEN - 1);
        else if (len != 4'd0)
            idx_first_d = IDX_W'(len - 4'd1);
    end

    assign len_zero_d  = (len == 4'd0);
    assign idx_dec_d   = idx_q - IDX_W'(1);
    // After the last press the trailing GAP cycles already belong to the unlock window.
    assign in_window_d = VERIFY && (idx_q == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            code_q  <= '0;
            idx_q   <= '0;
            gap_q   <= '0;
            win_q   <= '0;
            b0_q    <= 1'b0;
            b1_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            b0_q   <= 1'b0;
            b1_q   <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        code_q <= code;
                        idx_q  <= idx_first_d;
                        pass_q <= 1'b0;
                        fail_q <= 1'b0;
                        if (len_zero_d) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= S_PRESS;
                            busy_q  <= 1'b1;
                            b1_q    <= code[idx_first_d];
                            b0_q    <= ~code[idx_first_d];
                        end
                    end
                end
                S_PRESS: begin
                    state_q <= S_GAP;
                    gap_q   <= GAP_W'(GAP);
                    if (idx_q == '0)
                        win_q <= WIN_W'(UNLOCK_WAIT);
                end
                S_GAP: begin
                    if (in_window_d && unlock) begin
                        pass_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else if (in_window_d && (win_q == WIN_W'(1))) begin
                        fail_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        if (in_window_d)
                            win_q <= win_q - WIN_W'(1);
                        if (gap_q == GAP_W'(1)) begin
                            if (idx_q == '0) begin
                                if (VERIFY) begin
                                    state_q <= S_WAIT;
                                end else begin
                                    busy_q  <= 1'b0;
                                    done_q  <= 1'b1;
                                    state_q <= S_DONE;
                                end
                            end else begin
                                idx_q   <= idx_dec_d;
                                b1_q    <= code_q[idx_dec_d];
                                b0_q    <= ~code_q[idx_dec_d];
                                state_q <= S_PRESS;
                            end
                        end else begin
                            gap_q <= gap_q - GAP_W'(1);
                        end
                    end
                end
                S_WAIT: begin
                    if (unlock) begin
                        pass_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else if (win_q == WIN_W'(1)) begin
                        fail_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        win_q <= win_q - WIN_W'(1);
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign b0      = b0_q;
    assign b1      = b1_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign pass    = pass_q;
    assign fail    = fail_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_key_sequencer.sv
// Bench for key_sequencer: directed protocol cases plus random sends against a cycle-trace model built from the timing rules.
module tb_key_sequencer;
  localparam int ML = 8;
  localparam int G  = 2;
  localparam int W  = 4;
`ifdef KEY_SEQUENCER_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  code;
  logic [3:0]  len;
  logic        unlock;
  logic        b0, b1, busy, done, pass, fail;
  logic [2:0]  state_o;

  int total = 0;
  int bad   = 0;
  int txn_id = 0;

  // expected {b0,b1,busy,done,pass,fail} for each cycle after acceptance
  logic [5:0] exp_q[$];

  key_sequencer #(.MAX_LEN(ML), .GAP(G), .UNLOCK_WAIT(W)) dut (
    .clk(clk), .rst(rst), .start(start), .code(code), .len(len), .unlock(unlock),
    .b0(b0), .b1(b1), .busy(busy), .done(done), .pass(pass), .fail(fail),
    .state_o(state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  // Model: presses every G+1 cycles MSB-first, then the unlock window decides the end cycle.
  task automatic build_model(input logic [7:0] c, input logic [3:0] l, input int u);
    logic [5:0] tr [0:63];
    int n, last, fin;
    bit got_pass, got_fail;
    n = (int'(l) > ML) ? ML : int'(l);
    for (int t = 0; t < 64; t++) tr[t] = 6'b0;
    got_pass = 1'b0;
    got_fail = 1'b0;
    if (n == 0) begin
      fin = 1;
    end else begin
      last = 1 + (n - 1) * (G + 1);
      for (int k = 0; k < n; k++)
        tr[1 + k * (G + 1)][5:4] = c[n - 1 - k] ? 2'b01 : 2'b10;
      if (!VERIFY) begin
        fin = last + G + 1;
      end else if (u >= last + 1 && u <= last + W) begin
        fin = u + 1;
        got_pass = 1'b1;
      end else begin
        fin = last + W + 1;
        got_fail = 1'b1;
      end
    end
    for (int t = 1; t < fin; t++) tr[t][3] = 1'b1;
    tr[fin][2] = 1'b1;
    for (int t = fin; t <= fin + 1; t++) begin
      tr[t][1] = got_pass;
      tr[t][0] = got_fail;
    end
    exp_q.delete();
    for (int t = 1; t <= fin + 1; t++) exp_q.push_back(tr[t]);
  endtask

  // driver: accept at the next edge, then one check per cycle until one idle cycle after done
  task automatic run_txn(input logic [7:0] c, input logic [3:0] l, input int u, input bit noise);
    int t;
    logic [5:0] e;
    build_model(c, l, u);
    txn_id++;
    @(posedge clk); #1;
    start = 1'b1; code = c; len = l; unlock = 1'b0;
    t = 0;
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      t++;
      e = exp_q.pop_front();
      start  = (noise && exp_q.size() > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (noise) begin
        code = 8'($urandom);
        len  = 4'($urandom);
      end
      unlock = (t == u);
      @(negedge clk);
      check($sformatf("txn%0d_cyc%0d", txn_id, t), {b0, b1, busy, done, pass, fail}, e);
    end
    start  = 1'b0;
    unlock = 1'b0;
  endtask

  initial begin
    int n, lst, u;
    logic [7:0] c;
    logic [3:0] l;
    rst = 1'b0; start = 1'b0; code = '0; len = '0; unlock = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_state", {b0, b1, busy, done, pass, fail}, 6'b0);
    rst = 1'b1;
    @(negedge clk);
    check("idle_after_reset", {b0, b1, busy, done, pass, fail}, 6'b0);

    // correct code with lock response one cycle after the last press (T+14)
    run_txn(8'b0001_0010, 4'd5, 14, 1'b0);
    // wrong code: unlock never rises
    run_txn(8'b0001_0011, 4'd5, 0, 1'b0);
    // len=0: no presses, done one cycle after acceptance
    run_txn(8'hFF, 4'd0, 0, 1'b0);
    // len=12 clamps to 8; start/code/len toggled during the send
    run_txn(8'b1011_0110, 4'd12, 23, 1'b1);
    // unlock before the last press is ignored
    run_txn(8'b0110_1001, 4'd4, 7, 1'b0);
    // unlock on the last cycle of the window
    run_txn(8'b0000_0101, 4'd3, 7 + W, 1'b0);
    // unlock one cycle past the window
    run_txn(8'b0000_0101, 4'd3, 8 + W, 1'b0);

    // asynchronous reset in the third GAP cycle (cycle 5)
    @(posedge clk); #1;
    start = 1'b1; code = 8'hA5; len = 4'd8;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("pre_reset_busy", {b0, b1, busy, done, pass, fail}, 6'b001000);
    rst = 1'b0;
    #1;
    check("async_reset", {b0, b1, busy, done, pass, fail}, 6'b0);
    repeat (2) @(negedge clk);
    check("held_in_reset", {b0, b1, busy, done, pass, fail}, 6'b0);
    rst = 1'b1;
    run_txn(8'hA5, 4'd8, 23, 1'b0);

    // random sends with unlock biased around the window
    for (int i = 0; i < 40; i++) begin
      c = 8'($urandom);
      l = 4'($urandom_range(0, 15));
      n = (int'(l) > ML) ? ML : int'(l);
      lst = (n == 0) ? 0 : 1 + (n - 1) * (G + 1);
      u = (n == 0) ? 0 : int'($urandom_range(lst + W + 1, (lst > 3) ? lst - 3 : 0));
      run_txn(c, l, u, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
